// File: rtl/bcd_cnvt.sv
// bcd_cnvt: sequential binary-to-BCD converter (shift-and-add-3).
// Converts one bit per clock using a start/busy/done handshake.
// Ports:
//   CLK  - system clock, rising-edge active
//   Clr  - asynchronous active-low reset
//   S    - start request, accepted only while idle
//   Pin  - N-bit binary value, captured on the accepting edge
//   Busy - high while a conversion is in progress
//   Done - one-cycle completion pulse
//   D    - packed BCD result (D[3:0] = units), held until next completion
module bcd_cnvt #(
  parameter int unsigned N      = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                CLK,
  input  logic                Clr,
  input  logic                S,
  input  logic [N-1:0]        Pin,
  output logic                Busy,
  output logic                Done,
  output logic [4*DIGITS-1:0] D
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   d_q, d_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_sh;
  logic [N-1:0]    bin_sh;

  // Per-digit +3 correction (no carry between digits), then one-bit shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_sh = {bcd_adj[BW-2:0], bin_q[N-1]};
    bin_sh = {bin_q[N-2:0], 1'b0};
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (S) begin
          bin_d   = Pin;
          bcd_d   = '0;
          cnt_d   = CW'(N);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q - CW'(1);
        // Last shift: publish the result and return to idle.
        if (cnt_q == CW'(1)) begin
          d_d     = bcd_sh;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign D    = d_q;

endmodule

// File: tb/tb_bcd_cnvt.sv
// tb_bcd_cnvt: scoreboard bench for bcd_cnvt. A reference model predicts
// accepted starts and completion edges; a monitor checks every cycle.
module tb_bcd_cnvt;

  localparam int unsigned N      = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned BW     = 4 * DIGITS;

  logic          CLK = 1'b0;
  logic          Clr = 1'b0;
  logic          S   = 1'b0;
  logic [N-1:0]  Pin = '0;
  logic          Busy;
  logic          Done;
  logic [BW-1:0] D;

  bcd_cnvt #(.N(N), .DIGITS(DIGITS)) dut (
    .CLK(CLK), .Clr(Clr), .S(S), .Pin(Pin),
    .Busy(Busy), .Done(Done), .D(D)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [BW-1:0] val;
    int unsigned   done_edge;
  } exp_t;

  exp_t          q[$];
  int unsigned   edge_cnt = 0;
  int unsigned   next_ok  = 0;
  logic [BW-1:0] last_d   = '0;
  int            checks   = 0;
  int            errors   = 0;

  // Decimal digits by plain arithmetic.
  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   p;
    r = '0;
    p = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: an idle converter accepts S; result due N edges later.
  always @(posedge CLK) begin
    edge_cnt = edge_cnt + 1;
    if (Clr && S && edge_cnt >= next_ok) begin
      q.push_back('{to_bcd(int'(Pin)), edge_cnt + N});
      next_ok = edge_cnt + N + 1;
    end
  end

  // Asynchronous reset aborts everything and clears the result.
  always @(negedge Clr) begin
    q.delete();
    next_ok = 0;
    last_d  = '0;
  end

  // Monitor: sample away from the active edge.
  always @(negedge CLK) begin
    if (!Clr) begin
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || D !== '0) begin
        errors++;
        $display("FAIL reset_hold: Busy=%b Done=%b D=%h, expected 0 0 00000", Busy, Done, D);
      end
    end else begin
      checks++;
      if (Done === 1'b1) begin
        if (q.size() == 0 || q[0].done_edge != edge_cnt) begin
          errors++;
          $display("FAIL done_timing: unexpected Done at edge %0d", edge_cnt);
        end else begin
          checks++;
          if (D !== q[0].val) begin
            errors++;
            $display("FAIL done_value: D=%h expected %h", D, q[0].val);
          end
          last_d = q[0].val;
          void'(q.pop_front());
        end
      end else begin
        if (q.size() > 0 && q[0].done_edge == edge_cnt) begin
          errors++;
          $display("FAIL done_missing: Done=%b at edge %0d, expected 1", Done, edge_cnt);
          last_d = q[0].val;
          void'(q.pop_front());
        end else if (D !== last_d) begin
          errors++;
          $display("FAIL d_hold: D=%h expected %h", D, last_d);
        end
      end
      checks++;
      if (Busy !== (q.size() > 0)) begin
        errors++;
        $display("FAIL busy: Busy=%b expected %b at edge %0d", Busy, q.size() > 0, edge_cnt);
      end
    end
  end

  task automatic start(input logic [N-1:0] v);
    @(negedge CLK);
    S   = 1'b1;
    Pin = v;
    @(negedge CLK);
    S   = 1'b0;
    Pin = N'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse placed inside the low clock phase.
  task automatic pulse_reset();
    @(negedge CLK);
    #2 Clr = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || D !== '0) begin
      errors++;
      $display("FAIL reset_async: Busy=%b Done=%b D=%h, expected 0 0 00000", Busy, Done, D);
    end
    #1 Clr = 1'b1;
  endtask

  initial begin
    Clr = 1'b0;
    repeat (2) @(negedge CLK);
    #2 Clr = 1'b1;

    // Product of the multiplier, then boundary values.
    start(16'd60706);
    wait_idle();
    start(16'd0);      wait_idle();
    start(16'd9);      wait_idle();
    start(16'd10);     wait_idle();
    start(16'd65535);  wait_idle();

    // Start request while busy is ignored.
    start(16'd1234);
    repeat (4) @(negedge CLK);
    S = 1'b1; Pin = 16'd9999;
    @(negedge CLK);
    S = 1'b0;
    wait_idle();

    // S held high: back-to-back conversions.
    @(negedge CLK);
    S = 1'b1; Pin = 16'd100;
    repeat (17) @(negedge CLK);
    Pin = 16'd255;
    @(negedge CLK);
    S = 1'b0;
    wait_idle();

    // Reset mid-conversion, then restart.
    start(16'd4321);
    repeat (7) @(negedge CLK);
    pulse_reset();
    repeat (3) @(negedge CLK);
    start(16'd4321);
    wait_idle();

    // Random values with random start spam while busy.
    for (int t = 0; t < 40; t++) begin
      start(N'($urandom));
      for (int c = 0; c < int'($urandom_range(0, 18)); c++) begin
        @(negedge CLK);
        S   = 1'($urandom);
        Pin = N'($urandom);
      end
      S = 1'b0;
      if ($urandom_range(0, 9) == 0) pulse_reset();
      wait_idle();
    end

    // Reset while a random conversion runs.
    start(N'($urandom));
    repeat (5) @(negedge CLK);
    pulse_reset();
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
